// File: rtl/phase_selector_pkg.sv
// phase_selector_pkg: shared FSM states and width helpers for phase_selector
package phase_selector_pkg;
  localparam int NB_DATA_DEF = 16;
  localparam int OS_DEF = 4;
  localparam int NB_WIN_DEF = 10;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int nb_phase(input int os);
    return $clog2(os);
  endfunction
  function automatic int nb_acc(input int nb_data, input int nb_win);
    return nb_data - 1 + nb_win;
  endfunction
endpackage

// File: rtl/phase_selector_if.sv
// phase_selector_if: sample stream in, selected phase out
interface phase_selector_if import phase_selector_pkg::*; #(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int OS = OS_DEF
);
  logic i_valid;
  logic signed [NB_DATA-1:0] i_data;
  logic [nb_phase(OS)-1:0] o_phase;
  logic o_valid;
  modport master (output i_valid, i_data, input o_phase, o_valid);
  modport slave (input i_valid, i_data, output o_phase, o_valid);
endinterface

// File: rtl/phase_selector_abs_sat.sv
// abs_sat: saturating absolute value, most negative input maps to max positive
module abs_sat #(
  parameter int NB_DATA = 16
) (
  input  logic signed [NB_DATA-1:0] i_data,
  output logic [NB_DATA-2:0] o_mag
);
  assign o_mag = !i_data[NB_DATA-1] ? i_data[NB_DATA-2:0] :
                 (i_data[NB_DATA-2:0] == '0) ? '1 : -i_data[NB_DATA-2:0];
endmodule

// File: rtl/phase_selector.sv
// phase_selector: per-phase energy over 2^NB_WIN symbols, argmax on snapshot; PHASE_SEL_HYST_EN adds 12.5% hysteresis
module phase_selector import phase_selector_pkg::*; #(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int OS = OS_DEF,
  parameter int NB_WIN = NB_WIN_DEF
) (
  input logic i_clk,
  input logic i_rst,
  phase_selector_if.slave bus
);
  localparam int NB_PHASE = nb_phase(OS);
  localparam int NB_ACC = nb_acc(NB_DATA, NB_WIN);
  logic [NB_DATA-2:0] mag;
  logic [NB_PHASE-1:0] ph_q, idx_q, best_idx_q, o_phase_q;
  logic [NB_WIN-1:0] sym_q;
  logic [NB_ACC-1:0] acc_q [OS];
  logic [NB_ACC-1:0] snap_q [OS];
  logic [NB_ACC-1:0] best_q;
  state_t state_q;
  logic o_valid_q, win_end, take;
  abs_sat #(.NB_DATA(NB_DATA)) u_abs (.i_data(bus.i_data), .o_mag(mag));
  assign win_end = bus.i_valid && ph_q == NB_PHASE'(OS - 1) && &sym_q;
`ifdef PHASE_SEL_HYST_EN
  logic [NB_ACC:0] thr;
  assign thr = {1'b0, snap_q[o_phase_q]} + {4'b0, snap_q[o_phase_q][NB_ACC-1:3]};
  assign take = {1'b0, best_q} > thr;
`else
  assign take = 1'b1;
`endif
  assign bus.o_phase = o_phase_q;
  assign bus.o_valid = o_valid_q;
  // counters and accumulators advance on valid samples; window end snapshots and clears
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ph_q <= '0;
      sym_q <= '0;
      for (int k = 0; k < OS; k++) begin
        acc_q[k] <= '0;
        snap_q[k] <= '0;
      end
    end else if (bus.i_valid) begin
      ph_q <= ph_q + 1'b1;
      if (ph_q == NB_PHASE'(OS - 1)) sym_q <= sym_q + 1'b1;
      for (int k = 0; k < OS; k++) begin
        acc_q[k] <= win_end ? '0 : (ph_q == NB_PHASE'(k)) ? acc_q[k] + NB_ACC'(mag) : acc_q[k];
        if (win_end) snap_q[k] <= (ph_q == NB_PHASE'(k)) ? acc_q[k] + NB_ACC'(mag) : acc_q[k];
      end
    end
  end
  // scan FSM: one snapshot entry per cycle, strict greater keeps lowest index on ties
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      best_q <= '0;
      best_idx_q <= '0;
      o_phase_q <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (win_end) begin
          state_q <= SCAN;
          idx_q <= '0;
          best_q <= '0;
          best_idx_q <= '0;
        end
        SCAN: begin
          if (snap_q[idx_q] > best_q) begin
            best_q <= snap_q[idx_q];
            best_idx_q <= idx_q;
          end
          idx_q <= idx_q + 1'b1;
          if (idx_q == NB_PHASE'(OS - 1)) state_q <= DONE;
        end
        DONE: begin
          if (take) o_phase_q <= best_idx_q;
          o_valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phase_selector.sv
// tb_phase_selector: randomized and directed checks against a window-energy reference model
module tb_phase_selector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  phase_selector_if #(.NB_DATA(16), .OS(4)) ifa ();
  phase_selector_if #(.NB_DATA(16), .OS(4)) ifb ();
  phase_selector #(.NB_DATA(16), .OS(4), .NB_WIN(2)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.slave));
  phase_selector #(.NB_DATA(16), .OS(4), .NB_WIN(10)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.slave));
  int checks = 0;
  int failures = 0;
  logic qv[$];
  int qd[$];
  int ev_c[$];
  int ev_p[$];
  int mcnt;
  longint msum [4];
  int mphase;
  int exp_ph_a;

  function automatic int mag(input int d);
    return d == -32768 ? 32767 : (d < 0 ? -d : d);
  endfunction

  task automatic model_reset();
    mcnt = 0;
    mphase = 0;
    exp_ph_a = 0;
    for (int k = 0; k < 4; k++) msum[k] = 0;
    ev_c.delete();
    ev_p.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.i_valid = 1'b0;
    ifa.i_data = '0;
    ifb.i_valid = 1'b0;
    ifb.i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // window of 16 valid samples = 4 symbols x 4 phases, result published 5 edges after the last one
  task automatic model_step(input int c, input logic v, input int d);
    int bi;
    bit take;
    if (v) begin
      msum[mcnt % 4] += mag(d);
      mcnt++;
      if (mcnt % 16 == 0) begin
        bi = 0;
        for (int k = 1; k < 4; k++) if (msum[k] > msum[bi]) bi = k;
`ifdef PHASE_SEL_HYST_EN
        take = msum[bi] > msum[mphase] + msum[mphase] / 8;
`else
        take = 1'b1;
`endif
        if (take) mphase = bi;
        ev_c.push_back(c + 5);
        ev_p.push_back(mphase);
        for (int k = 0; k < 4; k++) msum[k] = 0;
      end
    end
  endtask

  task automatic push_win(input int p0, input int p1, input int p2, input int p3, input bit gap);
    int vals [4];
    vals = '{p0, p1, p2, p3};
    for (int i = 0; i < 16; i++) begin
      qv.push_back(1'b1);
      qd.push_back(vals[i % 4]);
      if (gap) begin
        qv.push_back(1'b0);
        qd.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
    end
  endtask

  task automatic run_a(input int pad, input string name);
    int n;
    int d;
    logic v;
    bit ev;
    n = qv.size();
    for (int c = 0; c < n + pad; c++) begin
      v = c < n ? qv[c] : 1'b0;
      d = c < n ? qd[c] : int'($urandom_range(0, 65535)) - 32768;
      @(negedge clk);
      ifa.i_valid = v;
      ifa.i_data = 16'(d);
      model_step(c, v, d);
      @(posedge clk);
      #1;
      ev = ev_c.size() > 0 && ev_c[0] == c;
      if (ev) begin
        exp_ph_a = ev_p[0];
        void'(ev_c.pop_front());
        void'(ev_p.pop_front());
      end
      checks++;
      if (ifa.o_valid !== ev) begin
        failures++;
        $display("FAIL %s o_valid cycle %0d got %b want %b", name, c, ifa.o_valid, ev);
      end
      checks++;
      if (ifa.o_phase !== 2'(exp_ph_a)) begin
        failures++;
        $display("FAIL %s o_phase cycle %0d got %0d want %0d", name, c, ifa.o_phase, exp_ph_a);
      end
    end
    ifa.i_valid = 1'b0;
    qv.delete();
    qd.delete();
  endtask

  task automatic run_b(input int pk, input int pv, input int exp_ph, input string name);
    for (int c = 0; c < 4096 + 8; c++) begin
      @(negedge clk);
      ifb.i_valid = c < 4096;
      ifb.i_data = 16'((c % 4 == pk) ? pv : 100);
      @(posedge clk);
      #1;
      if (c >= 4096) begin
        checks++;
        if (ifb.o_valid !== (c == 4100)) begin
          failures++;
          $display("FAIL %s o_valid cycle %0d got %b want %b", name, c, ifb.o_valid, c == 4100);
        end
      end
      if (c == 4100) begin
        checks++;
        if (ifb.o_phase !== 2'(exp_ph)) begin
          failures++;
          $display("FAIL %s o_phase got %0d want %0d", name, ifb.o_phase, exp_ph);
        end
      end
    end
    ifb.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ifa.o_phase !== 2'd0 || ifa.o_valid !== 1'b0 || ifb.o_phase !== 2'd0 || ifb.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got a=%0d/%b b=%0d/%b want 0/0", ifa.o_phase, ifa.o_valid, ifb.o_phase, ifb.o_valid);
    end
    push_win(0, 0, 0, 1000, 1'b0);
    run_a(7, "pre_reset");
    push_win(0, 1000, 0, 0, 1'b0);
    run_a(2, "mid_scan");
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifa.o_phase !== 2'd0 || ifa.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got %0d/%b want 0/0", ifa.o_phase, ifa.o_valid);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ifa.o_phase !== 2'd0 || ifa.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got %0d/%b want 0/0", ifa.o_phase, ifa.o_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      qv.push_back(1'b1);
      qd.push_back(i % 4 == 2 ? 1000 : 0);
    end
    run_a(10, "post_reset_partial");
    qv.push_back(1'b1);
    qd.push_back(0);
    run_a(7, "post_reset_complete");
  endtask

  task automatic test_single_peak();
    do_reset();
    push_win(0, 0, 1000, 0, 1'b0);
    run_a(8, "single_peak");
    checks++;
    if (ifa.o_phase !== 2'd2) begin
      failures++;
      $display("FAIL single_peak_final got %0d want 2", ifa.o_phase);
    end
  endtask

  task automatic test_tie();
    do_reset();
    push_win(0, 500, 0, -500, 1'b0);
    run_a(8, "tie");
    checks++;
    if (ifa.o_phase !== 2'd1) begin
      failures++;
      $display("FAIL tie_final got %0d want 1", ifa.o_phase);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    push_win(0, 0, 1000, 0, 1'b1);
    run_a(8, "gapped");
    checks++;
    if (ifa.o_phase !== 2'd2) begin
      failures++;
      $display("FAIL gapped_final got %0d want 2", ifa.o_phase);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    logic v;
    do_reset();
    nv = 0;
    while (nv < 16 * 8) begin
      v = $urandom_range(0, 3) != 0;
      qv.push_back(v);
      qd.push_back($urandom_range(0, 7) == 0 ? -32768 : int'($urandom_range(0, 65535)) - 32768);
      if (v) nv++;
    end
    run_a(8, "back_to_back");
  endtask

  task automatic test_hysteresis();
    do_reset();
    push_win(1000, 0, 0, 0, 1'b0);
    push_win(1000, 1100, 0, 0, 1'b0);
    run_a(8, "hyst_w12");
    checks++;
`ifdef PHASE_SEL_HYST_EN
    if (ifa.o_phase !== 2'd0) begin
      failures++;
      $display("FAIL hyst_w2 got %0d want 0", ifa.o_phase);
    end
`else
    if (ifa.o_phase !== 2'd1) begin
      failures++;
      $display("FAIL hyst_w2 got %0d want 1", ifa.o_phase);
    end
`endif
    push_win(1000, 1200, 0, 0, 1'b0);
    run_a(8, "hyst_w3");
    checks++;
    if (ifa.o_phase !== 2'd1) begin
      failures++;
      $display("FAIL hyst_w3 got %0d want 1", ifa.o_phase);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run_b(2, 5000, 2, "wide_peak");
    run_b(0, -32768, 0, "saturation");
    checks++;
    if (dut_b.snap_q[0] !== 25'(32767 * 1024)) begin
      failures++;
      $display("FAIL sat_snap got %0d want %0d", dut_b.snap_q[0], 32767 * 1024);
    end
  endtask

  initial begin
    ifa.i_valid = 1'b0;
    ifa.i_data = '0;
    ifb.i_valid = 1'b0;
    ifb.i_data = '0;
    test_reset();
    test_single_peak();
    test_tie();
    test_gapped();
    test_back_to_back();
    test_hysteresis();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
